// File: rtl/exec_seq_pkg.sv
// Purpose: shared state encodings, trap cause codes and helpers for the exec/memory sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exec_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_FETCH2 = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_LOAD   = 3'd3;
  localparam state_t S_ST_RD  = 3'd4;
  localparam state_t S_ST_WR  = 3'd5;
  localparam state_t S_WB     = 3'd6;

  localparam logic [31:0] CAUSE_IFAULT = 32'h0000_0001;
  localparam logic [31:0] CAUSE_LFAULT = 32'h0000_0005;
  localparam logic [31:0] CAUSE_SFAULT = 32'h0000_0007;
  localparam logic [31:0] CAUSE_MEXT   = 32'h8000_000B;

  // States that own the memory port.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_FETCH2) || (s == S_LOAD) ||
           (s == S_ST_RD) || (s == S_ST_WR);
  endfunction

  // Access-fault cause for a memory state that timed out.
  function automatic logic [31:0] fault_cause(input state_t s);
    logic [31:0] c;
    c = CAUSE_IFAULT;
    if (s == S_LOAD) c = CAUSE_LFAULT;
    else if ((s == S_ST_RD) || (s == S_ST_WR)) c = CAUSE_SFAULT;
    return c;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Purpose: counts cycles a memory request is held without ready; flags the access as expired.
// Latency: expired is combinational in the MEM_TIMEOUT-th waiting cycle of a request.
// Backpressure: none; completion (done) in the same cycle always suppresses expiry.
// Ports: clk, rst_n (async low); start clears the count (cycle before req rises);
//        busy = request high; done = ready; expired = give up on this access now.
module bus_timeout_counter #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  input  logic done,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(MEM_TIMEOUT - 1);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (busy && !done && (count != LAST)) begin
      count <= count + 16'd1;
    end
  end

  // count==LAST means this is the MEM_TIMEOUT-th cycle waiting.
  assign expired = busy & ~done & (count == LAST);

endmodule

// File: rtl/exec_mem_sequencer.sv
// Purpose: multi-cycle controller sequencing a single-cycle executor over one shared memory port
//          (fetch, split 32-bit fetch, load, store read-modify-write, writeback, traps).
// Latency: fetch(es) + 1 exec + data accesses + 1 writeback cycles per instruction.
// Backpressure: each access holds mem_req until mem_ready; MEM_TIMEOUT waiting cycles raise a fault.
// Ports: mem_* single memory port (req/we/addr/wdata out, ready/rdata in); pc/instr/read_data to
//        executor; ex_* decoded controls from executor; ext_irq level interrupt;
//        rd_we writeback strobe; trap_valid/trap_cause/trap_epc trap report.
module exec_mem_sequencer
  import exec_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] read_data,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic        ex_writes_rd,
  input  logic [31:0] ex_address,
  input  logic [31:0] ex_write_data,
  input  logic [31:0] ex_pc_next,
  input  logic        ex_redirect,
  input  logic        ex_trap,
  input  logic [31:0] ex_trap_cause,
  input  logic        ext_irq,
  output logic        rd_we,
  output logic        trap_valid,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_epc
);

  state_t      state, state_next;
  logic        mem_done, expired, req_next, trap_take;
  logic [31:0] cause_next, epc_next, addr_sel, pc_plus2, pc_seq;

  assign mem_done = mem_req & mem_ready;
  assign pc_plus2 = pc + 32'd2;
  // Sequential PC: 32-bit encodings advance 4, compressed ones 2.
  assign pc_seq   = ex_redirect ? ex_pc_next :
                    ((instr[1:0] == 2'b11) ? (pc + 32'd4) : pc_plus2);

  bus_timeout_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (req_next & ~mem_req),
    .busy    (mem_req),
    .done    (mem_ready),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next state and trap decision.
  always_comb begin
    state_next = state;
    trap_take  = 1'b0;
    cause_next = 32'h0;
    epc_next   = pc;
    case (state)
      S_FETCH:  if (mem_done)
                  state_next = (pc[1] && (mem_rdata[17:16] == 2'b11)) ? S_FETCH2 : S_EXEC;
      S_FETCH2: if (mem_done) state_next = S_EXEC;
      S_EXEC: begin
        if (ex_trap) begin
          trap_take  = 1'b1;
          cause_next = ex_trap_cause;
        end else if (ex_is_load) begin
          state_next = S_LOAD;
        end else if (ex_is_store) begin
          state_next = S_ST_RD;
        end else begin
          state_next = S_WB;
        end
      end
      S_LOAD:   if (mem_done) state_next = S_WB;
      S_ST_RD:  if (mem_done) state_next = S_ST_WR;
      S_ST_WR:  if (mem_done) state_next = S_WB;
      S_WB: begin
        state_next = S_FETCH;
        // Interrupt is taken after the writeback retires, so it returns to the next PC.
        if (ext_irq) begin
          trap_take  = 1'b1;
          cause_next = CAUSE_MEXT;
          epc_next   = pc_seq;
        end
      end
      default:  state_next = S_FETCH;
    endcase
    // expired is already masked by mem_ready, so a late completion wins.
    if (is_mem_state(state) && expired) begin
      trap_take  = 1'b1;
      cause_next = fault_cause(state);
    end
    if (trap_take) state_next = S_FETCH;
  end

  // Outputs decoded from state.
  always_comb begin
    rd_we    = (state == S_WB) & ex_writes_rd & ~ex_is_store;
    // Request drops for one cycle after every completion or fault.
    req_next = is_mem_state(state) & ~mem_done & ~expired;
    addr_sel = pc & 32'hFFFF_FFFC;
    case (state)
      S_FETCH2:                  addr_sel = pc_plus2 & 32'hFFFF_FFFC;
      S_LOAD, S_ST_RD, S_ST_WR:  addr_sel = ex_address & 32'hFFFF_FFFC;
      default:                   addr_sel = pc & 32'hFFFF_FFFC;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      instr      <= '0;
      read_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      trap_valid <= 1'b0;
      trap_cause <= '0;
      trap_epc   <= '0;
    end else begin
      mem_req <= req_next;
      mem_we  <= req_next & (state == S_ST_WR);
      // Address/data are captured in the idle cycle before req rises and held while it is high.
      if (!mem_req) mem_addr <= addr_sel;
      if (!mem_req && (state == S_ST_WR)) mem_wdata <= ex_write_data;
      if (mem_done) begin
        case (state)
          // For a split fetch the upper halfword parks in instr[15:0] until the second word.
          S_FETCH:         instr <= pc[1] ? {16'h0000, mem_rdata[31:16]} : mem_rdata;
          S_FETCH2:        instr <= {mem_rdata[15:0], instr[15:0]};
          S_LOAD, S_ST_RD: read_data <= mem_rdata;
          default:         ;
        endcase
      end
      trap_valid <= trap_take;
      if (trap_take) begin
        pc         <= TRAP_VEC;
        trap_cause <= cause_next;
        trap_epc   <= epc_next;
      end else if (state == S_WB) begin
        pc <= pc_seq;
      end
    end
  end

endmodule
